// File: rtl/j1_io_port.sv
// j1_io_port: I/O-space responder for the j1 core (TX FIFO, RX FIFO, STATUS, tick counter).
// Latency: io_din is registered, so data appears one cycle after io_rd; FIFO pushes reach the head next cycle.
// Backpressure: pause stalls CPU writes to a full TX FIFO; RX has none, so overflow drops the byte and sets ovf.
// Build option: define J1_IO_TICKS_EN to include the 16-bit free-running tick counter.

module j1_io_fifo #(
    parameter int LOG2 = 4
) (
    input  logic       clk,
    input  logic       resetq,
    input  logic       push,
    input  logic       pop,
    input  logic [7:0] wr_dat,
    output logic [7:0] rd_dat,
    output logic       empty,
    output logic       full
);
    // Byte FIFO. The caller qualifies push and pop, so this block never sees an illegal request.
    // The caller may push while full only if it also pops in the same cycle.
    localparam int DEPTH = 1 << LOG2;
    localparam logic [LOG2-1:0] PTR_ONE = 1;
    localparam logic [LOG2:0]   CNT_ONE = 1;

    logic [7:0]      mem_q [DEPTH];
    logic [7:0]      mem_d [DEPTH];
    logic [LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [LOG2:0]   count_q, count_d;

    assign rd_dat = mem_q[rd_ptr_q];
    assign empty  = (count_q == '0);
    assign full   = count_q[LOG2];

    // Next-state: write at the tail, advance the pointers, and track occupancy.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = wr_dat;
            wr_ptr_d        = wr_ptr_q + PTR_ONE;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    // State registers. Reset discards the contents at once.
    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end
endmodule

module j1_io_port #(
    parameter int TX_LOG2 = 4,
    parameter int RX_LOG2 = 4
) (
    input  logic        clk,
    input  logic        resetq,
    input  logic        io_rd,
    input  logic        io_wr,
    input  logic [15:0] io_addr,
    input  logic [15:0] io_dout,
    output logic [15:0] io_din,
    output logic        pause,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic [7:0]  rx_data,
    input  logic        rx_strobe
);
    logic        sel_data, sel_status, sel_ticks;
    logic        tx_push, tx_pop, tx_empty, tx_full;
    logic        rx_push, rx_pop, rx_empty, rx_full;
    logic [7:0]  rx_head;
    logic [15:0] ticks_val;
    logic [15:0] io_din_q, io_din_d;
    logic        ovf_q, ovf_d;
    logic        unused_bits;

    assign sel_data   = (io_addr[15:12] == 4'h1);
    assign sel_status = (io_addr[15:12] == 4'h2);
    assign sel_ticks  = (io_addr[15:12] == 4'h4);

    // A DATA write to a full TX FIFO stalls the CPU. The write stays held and lands
    // in the first cycle the FIFO has room. A pop in the full cycle frees the slot
    // only for the following cycle.
    assign pause   = io_wr & sel_data & tx_full;
    assign tx_push = io_wr & sel_data & ~tx_full;
    assign tx_pop  = tx_valid & tx_ready;

    // An empty DATA read is harmless: it returns zero and does not pop.
    // An RX push into a full FIFO is accepted only when the same cycle pops.
    assign rx_pop  = io_rd & sel_data & ~rx_empty;
    assign rx_push = rx_strobe & (~rx_full | rx_pop);

    assign tx_valid = ~tx_empty;
    assign io_din   = io_din_q;

    // Tie off the address and data bits that are never decoded.
    assign unused_bits = ^{io_addr[11:0], io_dout[15:8]};

    j1_io_fifo #(.LOG2(TX_LOG2)) u_tx_fifo (
        .clk    (clk),
        .resetq (resetq),
        .push   (tx_push),
        .pop    (tx_pop),
        .wr_dat (io_dout[7:0]),
        .rd_dat (tx_data),
        .empty  (tx_empty),
        .full   (tx_full)
    );

    j1_io_fifo #(.LOG2(RX_LOG2)) u_rx_fifo (
        .clk    (clk),
        .resetq (resetq),
        .push   (rx_push),
        .pop    (rx_pop),
        .wr_dat (rx_data),
        .rd_dat (rx_head),
        .empty  (rx_empty),
        .full   (rx_full)
    );

`ifdef J1_IO_TICKS_EN
    logic [15:0] ticks_q, ticks_d;

    // Free-running counter. A CPU load wins over the increment.
    always_comb begin
        ticks_d = ticks_q + 16'd1;
        if (io_wr & sel_ticks) begin
            ticks_d = io_dout;
        end
    end

    // Tick counter register.
    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            ticks_q <= 16'h0000;
        end else begin
            ticks_q <= ticks_d;
        end
    end

    assign ticks_val = ticks_q;
`else
    assign ticks_val = 16'h0000;
`endif

    // Read mux and the sticky overflow flag.
    // A drop in the same cycle as a clear leaves ovf set, so the event is not lost.
    always_comb begin
        io_din_d = io_din_q;
        ovf_d    = ovf_q;
        if (io_rd) begin
            case (io_addr[15:12])
                4'h1:    io_din_d = rx_empty ? 16'h0000 : {8'h00, rx_head};
                4'h2:    io_din_d = {12'h000, ovf_q, tx_empty, ~tx_full, ~rx_empty};
                4'h4:    io_din_d = ticks_val;
                default: io_din_d = 16'h0000;
            endcase
        end
        if (io_wr & sel_status & io_dout[3]) begin
            ovf_d = 1'b0;
        end
        if (rx_strobe & rx_full & ~rx_pop) begin
            ovf_d = 1'b1;
        end
    end

    // Read data and overflow registers.
    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            io_din_q <= 16'h0000;
            ovf_q    <= 1'b0;
        end else begin
            io_din_q <= io_din_d;
            ovf_q    <= ovf_d;
        end
    end
endmodule

// File: tb/tb_j1_io_port.sv
// tb_j1_io_port: directed bench for j1_io_port using scoreboard queues for reads and TX bytes.
// Latency: read results are popped one cycle after io_rd is issued; TX bytes are compared at each handshake.
// Backpressure: exercises pause on a full TX FIFO and RX overflow, including a pop in the same cycle.

module tb_j1_io_port;
    localparam logic [15:0] A_DATA  = 16'h1000;
    localparam logic [15:0] A_STAT  = 16'h2000;
    localparam logic [15:0] A_TICKS = 16'h4000;
    localparam logic [15:0] A_NONE  = 16'h3000;

    logic        clk = 1'b0;
    logic        resetq = 1'b0;
    logic        io_rd = 1'b0;
    logic        io_wr = 1'b0;
    logic [15:0] io_addr = '0;
    logic [15:0] io_dout = '0;
    logic [15:0] io_din;
    logic        pause;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b0;
    logic [7:0]  rx_data = '0;
    logic        rx_strobe = 1'b0;

    int n_err = 0;
    int n_chk = 0;

    // Scoreboards and a small behavioural model of FIFO contents.
    logic [15:0] rd_exp_q[$];
    string       rd_tag_q[$];
    logic [7:0]  tx_m[$];
    logic [7:0]  rx_m[$];
    logic        ovf_m = 1'b0;
    logic [15:0] last_din;

    j1_io_port dut (
        .clk       (clk),
        .resetq    (resetq),
        .io_rd     (io_rd),
        .io_wr     (io_wr),
        .io_addr   (io_addr),
        .io_dout   (io_dout),
        .io_din    (io_din),
        .pause     (pause),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .rx_data   (rx_data),
        .rx_strobe (rx_strobe)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: observed no finish, required finish within time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h required %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] stat_exp();
        return {12'h000, ovf_m, (tx_m.size() == 0), (tx_m.size() != 16), (rx_m.size() != 0)};
    endfunction

    task automatic rd_issue(input logic [15:0] addr, input logic [15:0] exp, input string tag);
        io_rd   = 1'b1;
        io_addr = addr;
        rd_exp_q.push_back(exp);
        rd_tag_q.push_back(tag);
    endtask

    task automatic rd_collect();
        last_din = rd_exp_q.pop_front();
        check(rd_tag_q.pop_front(), io_din, last_din);
    endtask

    task automatic rd(input logic [15:0] addr, input logic [15:0] exp, input string tag);
        rd_issue(addr, exp, tag);
        cyc();
        io_rd = 1'b0;
        rd_collect();
    endtask

    task automatic rd_data(input string tag);
        logic [15:0] e;
        e = (rx_m.size() != 0) ? {8'h00, rx_m.pop_front()} : 16'h0000;
        rd(A_DATA, e, tag);
    endtask

    task automatic wr(input logic [15:0] addr, input logic [15:0] dat);
        io_wr   = 1'b1;
        io_addr = addr;
        io_dout = dat;
        cyc();
        io_wr   = 1'b0;
    endtask

    task automatic strobe(input logic [7:0] b);
        rx_strobe = 1'b1;
        rx_data   = b;
        if (rx_m.size() < 16) rx_m.push_back(b);
        else ovf_m = 1'b1;
        cyc();
        rx_strobe = 1'b0;
    endtask

    task automatic drain(input int n);
        tx_ready = 1'b1;
        for (int i = 0; i < n; i++) begin
            check("tx_valid_drain", {15'h0, tx_valid}, 16'h0001);
            check("tx_order", {8'h00, tx_data}, {8'h00, tx_m.pop_front()});
            cyc();
        end
        tx_ready = 1'b0;
    endtask

    initial begin
        // Reset.
        repeat (2) @(posedge clk);
        #1 resetq = 1'b1;
        check("reset_tx_valid", {15'h0, tx_valid}, 16'h0000);
        check("reset_pause", {15'h0, pause}, 16'h0000);
        check("reset_io_din", io_din, 16'h0000);
        rd(A_STAT, stat_exp(), "status_reset");

        // First TX byte: the upper data byte is ignored.
        wr(A_DATA, 16'hAB41);
        tx_m.push_back(8'h41);
        check("tx_valid_first", {15'h0, tx_valid}, 16'h0001);
        check("tx_data_first", {8'h00, tx_data}, 16'h0041);
        rd(A_STAT, stat_exp(), "status_one_tx");

        // Fill the TX FIFO to 16 entries.
        for (int i = 1; i < 16; i++) begin
            wr(A_DATA, {8'hFF, 8'(8'h41 + i)});
            tx_m.push_back(8'(8'h41 + i));
        end
        rd(A_STAT, stat_exp(), "status_tx_full");

        // 17th write stalls until one TX pop frees a slot.
        io_wr   = 1'b1;
        io_addr = A_DATA;
        io_dout = 16'h0099;
        #1;
        check("pause_on_full", {15'h0, pause}, 16'h0001);
        cyc();
        check("pause_held", {15'h0, pause}, 16'h0001);
        check("tx_head_while_paused", {8'h00, tx_data}, 16'h0041);
        tx_ready = 1'b1;
        check("tx_order_pause_pop", {8'h00, tx_data}, {8'h00, tx_m.pop_front()});
        cyc();
        tx_ready = 1'b0;
        check("pause_drops", {15'h0, pause}, 16'h0000);
        tx_m.push_back(8'h99);
        cyc();
        io_wr = 1'b0;
        drain(16);
        check("tx_empty_after_drain", {15'h0, tx_valid}, 16'h0000);

        // RX overflow: 17 strobes with no reads.
        for (int i = 0; i < 17; i++) strobe(8'(i));
        rd(A_STAT, stat_exp(), "status_rx_ovf");
        for (int i = 0; i < 16; i++) rd_data("rx_read");
        rd_data("rx_read_empty");
        wr(A_STAT, 16'h0008);
        ovf_m = 1'b0;
        rd(A_STAT, stat_exp(), "status_ovf_cleared");
        cyc();
        cyc();
        check("io_din_hold", io_din, last_din);

        // RX full: strobe and DATA read in the same cycle.
        for (int i = 0; i < 16; i++) strobe(8'(8'h20 + i));
        rd(A_STAT, stat_exp(), "status_rx_full");
        rx_strobe = 1'b1;
        rx_data   = 8'h55;
        rd_issue(A_DATA, {8'h00, rx_m.pop_front()}, "rx_read_with_push");
        rx_m.push_back(8'h55);
        cyc();
        rx_strobe = 1'b0;
        io_rd     = 1'b0;
        rd_collect();
        rd(A_STAT, stat_exp(), "status_full_no_ovf");
        for (int i = 0; i < 16; i++) rd_data("rx_read_after_full");
        rd(A_NONE, 16'h0000, "unmapped_read");

        // A DATA read and a DATA write in the same cycle touch different FIFOs.
        io_wr   = 1'b1;
        io_dout = 16'h0077;
        rd_issue(A_DATA, 16'h0000, "rd_wr_same_cycle");
        tx_m.push_back(8'h77);
        cyc();
        io_wr = 1'b0;
        io_rd = 1'b0;
        rd_collect();
        check("tx_data_rd_wr", {8'h00, tx_data}, 16'h0077);

        // An asynchronous reset in mid-cycle empties the FIFOs at once.
        #2 resetq = 1'b0;
        #1;
        check("async_reset_tx_valid", {15'h0, tx_valid}, 16'h0000);
        tx_m.delete();
        rx_m.delete();
        ovf_m = 1'b0;
        @(posedge clk);
        #1 resetq = 1'b1;
        rd(A_STAT, stat_exp(), "status_after_async_reset");

        // Ticks: load FFFE, wait one cycle, then read back to back.
        wr(A_TICKS, 16'hFFFE);
        cyc();
`ifdef J1_IO_TICKS_EN
        rd_issue(A_TICKS, 16'hFFFF, "ticks_first");
`else
        rd_issue(A_TICKS, 16'h0000, "ticks_first");
`endif
        cyc();
        rd_collect();
`ifdef J1_IO_TICKS_EN
        rd_issue(A_TICKS, 16'h0000, "ticks_wrap");
`else
        rd_issue(A_TICKS, 16'h0000, "ticks_wrap");
`endif
        cyc();
        io_rd = 1'b0;
        rd_collect();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
